// File: rtl/reorder_pkg.sv
// Shared reorder-tag types: packet status codes, allocator states and the
// modulo-SIZE pointer increment. Also imported by circular_buffer.
package reorder_pkg;

  typedef logic [1:0] status_t;

  localparam status_t PENDING  = 2'b00;
  localparam status_t REJECTED = 2'b01;
  localparam status_t ACCEPTED = 2'b11;

  typedef enum logic {
    IDLE,
    IN_PKT
  } alloc_state_t;

  function automatic int unsigned wrap_inc(input int unsigned ptr, input int unsigned size);
    return (ptr == size - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/reorder_status_table.sv
// Per-tag packet status table: verdict/release writes, async read port and
// in-flight tracking. Define REORDER_STATUS_TIMEOUT_EN for per-entry auto-reject.
module reorder_status_table
  import reorder_pkg::*;
#(
  parameter int unsigned TAG_WIDTH      = 6,
  parameter int unsigned SIZE           = 3,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 alloc_en,
  input  logic [TAG_WIDTH-1:0] alloc_tag,
  input  logic                 rel_en,
  input  logic [TAG_WIDTH-1:0] rel_tag,
  input  logic                 verdict_valid,
  input  logic [TAG_WIDTH-1:0] verdict_tag,
  input  logic                 verdict_accept,
  input  logic [TAG_WIDTH-1:0] rd_tag,
  output logic [1:0]           rd_status,
  output logic                 err_verdict
`ifdef REORDER_STATUS_TIMEOUT_EN
  ,
  output logic                 timeout_pulse
`endif
);

  status_t         status_q [SIZE];
  logic [SIZE-1:0] in_flight;
  logic            verdict_ok;
  logic            rel_covers_verdict;

`ifdef REORDER_STATUS_TIMEOUT_EN
  localparam int unsigned AGE_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [AGE_W-1:0] age_q [SIZE];
`endif

  // Tags >= SIZE match no entry, so they read PENDING and never verdict legally.
  always_comb begin
    rd_status  = PENDING;
    verdict_ok = 1'b0;
    for (int unsigned i = 0; i < SIZE; i++) begin
      if (rd_tag == TAG_WIDTH'(i))
        rd_status = status_q[i];
      if (verdict_tag == TAG_WIDTH'(i) && in_flight[i] && status_q[i] == PENDING)
        verdict_ok = 1'b1;
    end
  end

  assign rel_covers_verdict = rel_en && (rel_tag == verdict_tag);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < SIZE; i++) begin
        status_q[i] <= PENDING;
`ifdef REORDER_STATUS_TIMEOUT_EN
        age_q[i]    <= '0;
`endif
      end
      in_flight   <= '0;
      err_verdict <= 1'b0;
`ifdef REORDER_STATUS_TIMEOUT_EN
      timeout_pulse <= 1'b0;
`endif
    end else begin
      err_verdict <= verdict_valid && !verdict_ok && !rel_covers_verdict;
`ifdef REORDER_STATUS_TIMEOUT_EN
      timeout_pulse <= 1'b0;
`endif
      for (int unsigned i = 0; i < SIZE; i++) begin
        // Release outranks a same-cycle verdict; a live verdict outranks the timeout.
        if (rel_en && rel_tag == TAG_WIDTH'(i)) begin
          status_q[i]  <= PENDING;
          in_flight[i] <= 1'b0;
        end else if (verdict_valid && verdict_ok && verdict_tag == TAG_WIDTH'(i)) begin
          status_q[i] <= verdict_accept ? ACCEPTED : REJECTED;
        end
`ifdef REORDER_STATUS_TIMEOUT_EN
        else if (in_flight[i] && status_q[i] == PENDING) begin
          if (age_q[i] == AGE_W'(TIMEOUT_CYCLES - 1)) begin
            status_q[i]   <= REJECTED;
            timeout_pulse <= 1'b1;
          end else begin
            age_q[i] <= age_q[i] + 1'b1;
          end
        end
`endif
        if (alloc_en && alloc_tag == TAG_WIDTH'(i)) begin
          in_flight[i] <= 1'b1;
`ifdef REORDER_STATUS_TIMEOUT_EN
          age_q[i]     <= '0;
`endif
        end
      end
    end
  end

endmodule

// File: rtl/reorder_tag_alloc.sv
// Reorder-tag allocator: stamps packets with in-order tags through a one-stage
// output slice and owns the status table. Optional REORDER_STATUS_TIMEOUT_EN.
module reorder_tag_alloc
  import reorder_pkg::*;
#(
  parameter int unsigned TAG_WIDTH            = 6,
  parameter int unsigned CIRCULAR_BUFFER_SIZE = 3,
  parameter int unsigned DATA_WIDTH           = 64,
  parameter int unsigned TIMEOUT_CYCLES       = 1024
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [DATA_WIDTH-1:0]                     s_TDATA,
  input  logic                                      s_TLAST,
  input  logic                                      s_TVALID,
  output logic                                      s_TREADY,
  output logic [DATA_WIDTH-1:0]                     m_TDATA,
  output logic                                      m_TLAST,
  output logic                                      m_TVALID,
  input  logic                                      m_TREADY,
  output logic [TAG_WIDTH-1:0]                      m_tag,
  input  logic                                      verdict_valid,
  input  logic [TAG_WIDTH-1:0]                      verdict_tag,
  input  logic                                      verdict_accept,
  input  logic [TAG_WIDTH-1:0]                      reorder_tag_out,
  output logic [1:0]                                packet_status,
  input  logic                                      tag_release,
  output logic [$clog2(CIRCULAR_BUFFER_SIZE+1)-1:0] outstanding,
  output logic                                      err_verdict
`ifdef REORDER_STATUS_TIMEOUT_EN
  ,
  output logic                                      timeout_pulse
`endif
);

  localparam int unsigned SIZE  = CIRCULAR_BUFFER_SIZE;
  localparam int unsigned OUT_W = $clog2(SIZE + 1);

  alloc_state_t         state;
  logic [TAG_WIDTH-1:0] alloc_ptr;
  logic [TAG_WIDTH-1:0] rel_ptr;
  logic [TAG_WIDTH-1:0] cur_tag;
  logic                 slot_free;
  logic                 full;
  logic                 accept;
  logic                 first_beat;
  logic                 rel_valid;

  // Fullness uses the registered count, so a same-cycle release cannot admit a new packet.
  assign slot_free  = !m_TVALID || m_TREADY;
  assign full       = (outstanding == OUT_W'(SIZE));
  assign s_TREADY   = rst && slot_free && ((state == IN_PKT) || !full);
  assign accept     = s_TVALID && s_TREADY;
  assign first_beat = accept && (state == IDLE);
  assign rel_valid  = tag_release && (reorder_tag_out == rel_ptr) && (outstanding != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      alloc_ptr   <= '0;
      rel_ptr     <= '0;
      cur_tag     <= '0;
      outstanding <= '0;
      m_TDATA     <= '0;
      m_TLAST     <= 1'b0;
      m_TVALID    <= 1'b0;
      m_tag       <= '0;
    end else begin
      if (accept) begin
        m_TDATA  <= s_TDATA;
        m_TLAST  <= s_TLAST;
        m_tag    <= first_beat ? alloc_ptr : cur_tag;
        m_TVALID <= 1'b1;
        state    <= s_TLAST ? IDLE : IN_PKT;
      end else if (m_TREADY) begin
        m_TVALID <= 1'b0;
      end

      if (first_beat) begin
        cur_tag   <= alloc_ptr;
        alloc_ptr <= TAG_WIDTH'(wrap_inc(32'(alloc_ptr), SIZE));
      end
      if (rel_valid)
        rel_ptr <= TAG_WIDTH'(wrap_inc(32'(rel_ptr), SIZE));

      if (first_beat && !rel_valid)
        outstanding <= outstanding + 1'b1;
      else if (!first_beat && rel_valid)
        outstanding <= outstanding - 1'b1;
    end
  end

  reorder_status_table #(
    .TAG_WIDTH     (TAG_WIDTH),
    .SIZE          (SIZE),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_status_table (
    .clk           (clk),
    .rst           (rst),
    .alloc_en      (first_beat),
    .alloc_tag     (alloc_ptr),
    .rel_en        (rel_valid),
    .rel_tag       (rel_ptr),
    .verdict_valid (verdict_valid),
    .verdict_tag   (verdict_tag),
    .verdict_accept(verdict_accept),
    .rd_tag        (reorder_tag_out),
    .rd_status     (packet_status),
    .err_verdict   (err_verdict)
`ifdef REORDER_STATUS_TIMEOUT_EN
    ,
    .timeout_pulse (timeout_pulse)
`endif
  );

endmodule

// File: doc/reorder_tag_alloc.md
Name: reorder_tag_alloc

Overview:
- Sits directly upstream of circular_buffer and owns the reorder-tag lifecycle.
- Stamps each incoming AXI-Stream packet with the next in-order reorder tag and forwards the packet through a one-stage register slice to circular_buffer (buffer_TDATA/reorder_tag_in).
- Holds the per-tag packet status table. Filter engines write accept/reject verdicts into it; circular_buffer reads it through packet_status[reorder_tag_out].
- Frees each tag when circular_buffer retires the packet that carried it.

Parameters:
- TAG_WIDTH, 6, width of reorder tags.
- CIRCULAR_BUFFER_SIZE, 3, number of tags in flight; tags run 0..SIZE-1. Must satisfy SIZE <= 2^TAG_WIDTH.
- DATA_WIDTH, 64, TDATA width.
- TIMEOUT_CYCLES, 1024, pending lifetime before auto-reject. Used only with STATUS_TIMEOUT_EN.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-low.
- s_TDATA  in  DATA_WIDTH  upstream packet data.
- s_TLAST  in  1  upstream last beat.
- s_TVALID  in  1  upstream valid.
- s_TREADY  out  1  upstream ready.
- m_TDATA  out  DATA_WIDTH  to circular_buffer buffer_TDATA.
- m_TLAST  out  1  to buffer_TLAST.
- m_TVALID  out  1  to buffer_TVALID.
- m_TREADY  in  1  from buffer_TREADY.
- m_tag  out  TAG_WIDTH  to reorder_tag_in; constant for all beats of a packet.
- verdict_valid  in  1  filter verdict strobe.
- verdict_tag  in  TAG_WIDTH  tag the verdict applies to.
- verdict_accept  in  1  1 = ACCEPTED, 0 = REJECTED.
- reorder_tag_out  in  TAG_WIDTH  tag circular_buffer is inspecting.
- packet_status  out  2  status of reorder_tag_out (combinational table read).
- tag_release  in  1  circular_buffer has retired the packet at reorder_tag_out.
- outstanding  out  $clog2(SIZE+1)  number of tags in flight.
- err_verdict  out  1  one-cycle pulse on an illegal verdict.

Behaviour:
- Status encoding: PENDING = 2'b00, REJECTED = 2'b01, ACCEPTED = 2'b11. Reset writes PENDING to every entry.
- Reset (rst = 0, async) clears, in every register:
  - m_TVALID = 0, m_TLAST = 0, m_TDATA = 0, m_tag = 0.
  - alloc_ptr = 0, rel_ptr = 0, outstanding = 0, state = IDLE, err_verdict = 0.
  - s_TREADY = 0 while rst is low.
  - A packet cut by reset is lost. Upstream restarts at a packet boundary; there is no recovery of partial packets.
- FSM states:
  - IDLE: waiting for a first beat.
    - s_TREADY = slot_free && (outstanding < SIZE). slot_free = !m_TVALID || m_TREADY.
    - On a first-beat accept: cur_tag <= alloc_ptr; alloc_ptr <= (alloc_ptr == SIZE-1) ? 0 : alloc_ptr+1; outstanding increments.
    - Go to IN_PKT unless that beat has TLAST, in which case stay in IDLE.
  - IN_PKT: s_TREADY = slot_free; no allocation. The beat with TLAST returns to IDLE.
- Output slice:
  - Each accepted beat loads m_TDATA/m_TLAST/m_tag and sets m_TVALID = 1.
  - m_TVALID clears when m_TREADY = 1 and no new beat arrives.
  - Latency is 1 cycle. Throughput is 1 beat/cycle while m_TREADY = 1.
  - m_* outputs hold while m_TVALID = 1 and m_TREADY = 0.
- Full: fullness is evaluated from the registered outstanding count. At outstanding == SIZE, a new packet stalls in IDLE even if tag_release is asserted in the same cycle. Packets already in IN_PKT are never stalled by fullness.
- Verdict:
  - Legal when verdict_tag is in flight and its entry is PENDING; writes the entry on the next edge.
  - Otherwise the write is ignored and err_verdict pulses. Illegal cases: tag not in flight, entry already decided (first verdict is sticky), or tag >= SIZE.
- Release:
  - tag_release requires reorder_tag_out == rel_ptr and outstanding > 0; otherwise it is ignored.
  - A valid release sets the entry to PENDING, wraps rel_ptr like alloc_ptr, and decrements outstanding.
- Simultaneous events:
  - Allocate and release in the same cycle: outstanding is unchanged.
  - Verdict and release on the same tag: release wins and the entry becomes PENDING. No err_verdict.
- packet_status: status_table[reorder_tag_out]; returns PENDING when reorder_tag_out >= SIZE.

Optional Feature:
- Macro REORDER_STATUS_TIMEOUT_EN.
- When defined: each entry has an age counter, cleared at allocation. An entry still PENDING after TIMEOUT_CYCLES cycles is forced to REJECTED, so a lost filter verdict cannot deadlock the reorder buffer.
  - Adds an output timeout_pulse (1 bit) that pulses in the cycle the entry is forced.
  - A verdict on a timed-out entry sets err_verdict.
- When undefined: no counters; an entry stays PENDING until a verdict arrives.

Decomposition:
- Shared package reorder_pkg: status localparams PENDING/REJECTED/ACCEPTED, status_t (2 bits), FSM state encoding IDLE/IN_PKT, and a wrap-increment function for pointers modulo SIZE. circular_buffer also imports this package.
- One natural sub-module: reorder_status_table. It holds the status entries, the verdict/release write logic, the async read port and the optional timeout counters. The allocator FSM and output slice stay in the top module.

Test Plan:
- Back-to-back packets of 2, 1 and 3 beats with m_TREADY = 1 -> m_tag = 0, 1, 2. Each beat appears one cycle after acceptance. outstanding reaches 3.
- Full boundary: with 3 tags outstanding and a 4th packet offered -> s_TREADY = 0. tag_release with reorder_tag_out = 0 -> the packet is accepted the following cycle with m_tag = 0 (wrap-around).
- Verdicts: verdict_tag = 1 ACCEPT, then tag 1 REJECT -> packet_status for tag 1 = 2'b11; the second verdict raises err_verdict. Verdict on non-outstanding tag 2 -> err_verdict, table unchanged.
- Backpressure: random m_TREADY at 60% over 10 packets -> no beat lost or duplicated, and m_tag stays constant within each packet.
- Out-of-order release: tag_release with reorder_tag_out = 1 while rel_ptr = 0 -> ignored, outstanding unchanged. Assert rst low mid-packet -> all outputs at reset values immediately and every status entry PENDING.
- With REORDER_STATUS_TIMEOUT_EN and TIMEOUT_CYCLES = 16, no verdict -> packet_status becomes 2'b01 after 16 cycles and timeout_pulse pulses once.
